// File: rtl/dwt_pass_sequencer_pkg.sv
// Shared state codes, pass-mode constants and address-width helper for the
// DWT pass sequencer.
package dwt_pass_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ROW       = 3'd1;
  localparam state_t S_ROW_DRAIN = 3'd2;
  localparam state_t S_COL       = 3'd3;
  localparam state_t S_COL_DRAIN = 3'd4;
  localparam state_t S_DONE      = 3'd5;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  function automatic int dwt_aw(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

endpackage

// File: rtl/dwt_pass_sequencer_if.sv
// Pair-request / result-return link between the pass sequencer and the
// lifting MAC, plus the bank select the memory muxes follow.
interface dwt_pass_sequencer_if #(parameter int AW = 8);
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_mode;
  logic [AW-1:0] rd_line;
  logic [AW-1:0] rd_pixel;
  logic          bank_sel;
  logic          res_valid;

  modport master (output rd_valid, rd_mode, rd_line, rd_pixel, bank_sel,
                  input  rd_ready, res_valid);
  modport slave  (input  rd_valid, rd_mode, rd_line, rd_pixel, bank_sel,
                  output rd_ready, res_valid);
endinterface

// File: rtl/dwt_pass_sequencer_scan_counter.sv
// Line/pixel walker for one pass: pixel steps by 2 and wraps into the next
// line at pix_lim; last flags the final pair of the region.
module dwt_scan_counter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clr,
  input  logic [AW-1:0] pix_lim,
  input  logic [AW-1:0] line_lim,
  output logic [AW-1:0] pixel,
  output logic [AW-1:0] line,
  output logic          last
);

  logic wrap;

  assign wrap = (pixel == pix_lim);
  assign last = wrap && (line == line_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel <= '0;
      line  <= '0;
    end else if (clr) begin
      pixel <= '0;
      line  <= '0;
    end else if (step) begin
      if (wrap) begin
        pixel <= '0;
        line  <= line + AW'(1);
      end else begin
        pixel <= pixel + AW'(2);
      end
    end
  end

endmodule

// File: rtl/dwt_pass_sequencer.sv
// Multi-level 2D DWT pass sequencer: row then column pass per level over the
// ping-pong banks, with an outstanding-pair window toward the lifting MAC.
module dwt_pass_sequencer
  import dwt_pass_sequencer_pkg::*;
#(
  parameter int HEIGHT              = 256,
  parameter int WIDTH               = 256,
  parameter int DECOMPOSITION_LEVEL = 1,
  parameter int MAX_OUTSTANDING     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  dwt_pass_sequencer_if.master        bus,
  output logic [2:0]                  level,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int AW = dwt_aw(WIDTH, HEIGHT);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  state_t        state;
  logic [OW-1:0] cnt, cnt_nxt;
  logic [OW:0]   ghost, ghost_dec;
  logic          mode, bank;
  logic          issue, stale, live, err_set, last, clr, drained;
  logic [AW:0]   w_l, h_l;
  logic [AW-1:0] pix_lim, line_lim, pixel, line;

  assign bus.rd_valid = ((state == S_ROW) || (state == S_COL)) &&
                        (cnt != OW'(MAX_OUTSTANDING));
  assign issue = bus.rd_valid && bus.rd_ready;

  // Results still in flight from an aborted run are absorbed by ghost so
  // they neither count against the new window nor raise err.
  assign stale     = bus.res_valid && (ghost != '0);
  assign live      = bus.res_valid && (ghost == '0);
  assign ghost_dec = stale ? ghost - (OW+1)'(1) : ghost;
  assign err_set   = live && !issue && (cnt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (issue && !live)
      cnt_nxt = cnt + OW'(1);
    else if (live && !issue && (cnt != '0))
      cnt_nxt = cnt - OW'(1);
  end

  // Region one bit wider than AW so a full-size edge (e.g. 256) is exact
  // before subtracting.
  assign w_l      = (AW+1)'(WIDTH)  >> level;
  assign h_l      = (AW+1)'(HEIGHT) >> level;
  assign pix_lim  = (mode == MODE_COL) ? AW'(h_l - (AW+1)'(2)) : AW'(w_l - (AW+1)'(2));
  assign line_lim = (mode == MODE_COL) ? AW'(w_l - (AW+1)'(1)) : AW'(h_l - (AW+1)'(1));

  assign drained = ((state == S_ROW_DRAIN) || (state == S_COL_DRAIN)) && (cnt == '0);
  assign clr     = !abort && (((state == S_IDLE) && start) || drained);

  dwt_scan_counter #(.AW(AW)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .step     (issue),
    .clr      (clr),
    .pix_lim  (pix_lim),
    .line_lim (line_lim),
    .pixel    (pixel),
    .line     (line),
    .last     (last)
  );

  assign bus.rd_pixel = pixel;
  assign bus.rd_line  = line;
  assign bus.rd_mode  = mode;
  assign bus.bank_sel = bank;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ghost <= '0;
      mode  <= MODE_ROW;
      bank  <= 1'b0;
      level <= '0;
      err   <= 1'b0;
    end else begin
      err <= err | err_set;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        cnt   <= '0;
        ghost <= ghost_dec + (OW+1)'(cnt_nxt);
      end else begin
        cnt   <= cnt_nxt;
        ghost <= ghost_dec;
        case (state)
          S_IDLE: if (start && !abort) begin
            state <= S_ROW;
            mode  <= MODE_ROW;
            bank  <= 1'b0;
            level <= '0;
            err   <= 1'b0;
          end
          S_ROW: if (issue && last) state <= S_ROW_DRAIN;
          S_ROW_DRAIN: if (drained) begin
            state <= S_COL;
            mode  <= MODE_COL;
            bank  <= ~bank;
          end
          S_COL: if (issue && last) state <= S_COL_DRAIN;
          S_COL_DRAIN: if (drained) begin
            bank  <= ~bank;
            level <= level + 3'd1;
            if (level == 3'(DECOMPOSITION_LEVEL - 1)) begin
              state <= S_DONE;
            end else begin
              state <= S_ROW;
              mode  <= MODE_ROW;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dwt_pass_sequencer.sv
// Randomized bench for dwt_pass_sequencer: a pass-level reference model
// predicts every output each cycle; literal totals pin the model.
module tb_dwt_pass_sequencer;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int DL   = 2;
  localparam int MAXO = 4;
  localparam int AW   = 4;
  localparam int TOTAL_ISSUES = 160;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0] level;
  logic busy, done, err;

  dwt_pass_sequencer_if #(.AW(AW)) bus();

  dwt_pass_sequencer #(
    .HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(DL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .level(level), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int issue_cnt = 0, done_cnt = 0, done_level = -1, done_bank = -1;
  int ready_pct = 100, delay = 2;
  logic extra_res = 1'b0;
  logic [31:0] sched = '0;

  // reference model state (pass index p: level p/2, column pass when p odd)
  int m_active = 0, m_issuing = 0, m_drain = 0, m_done = 0;
  int m_pass = 0, m_issued = 0, m_cnt = 0, m_ghost = 0;
  int m_err = 0, m_bank = 0, m_level = 0, m_mode = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int plen(input int p);
    return ((W >> (p / 2)) * (H >> (p / 2))) / 2;
  endfunction

  function automatic int per_line(input int p);
    return ((p % 2) == 0) ? (W >> (p / 2)) / 2 : (H >> (p / 2)) / 2;
  endfunction

  // model update on each active edge
  initial begin : model
    int old_cnt;
    bit iss, stale, live;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 0; m_issuing = 0; m_drain = 0; m_done = 0; m_pass = 0;
        m_issued = 0; m_cnt = 0; m_ghost = 0; m_err = 0; m_bank = 0;
        m_level = 0; m_mode = 0;
      end else begin
        old_cnt = m_cnt;
        iss   = (m_issuing != 0) && (m_cnt < MAXO) && bus.rd_ready;
        stale = bus.res_valid && (m_ghost > 0);
        live  = bus.res_valid && !stale;
        if (stale) m_ghost--;
        if (live && old_cnt == 0 && !iss) m_err = 1;
        if (iss && !live) m_cnt++;
        else if (live && !iss && m_cnt > 0) m_cnt--;
        if (m_active != 0 && abort) begin
          m_ghost += m_cnt; m_cnt = 0;
          m_active = 0; m_issuing = 0; m_drain = 0; m_done = 0;
        end else if (m_active == 0) begin
          if (start && !abort) begin
            m_active = 1; m_issuing = 1; m_pass = 0; m_issued = 0;
            m_level = 0; m_bank = 0; m_err = 0; m_mode = 0;
          end
        end else if (m_done != 0) begin
          m_done = 0; m_active = 0;
        end else if (m_issuing != 0) begin
          if (iss) begin
            m_issued++;
            if (m_issued == plen(m_pass)) begin m_issuing = 0; m_drain = 1; end
          end
        end else if (m_drain != 0 && old_cnt == 0) begin
          m_drain = 0; m_bank ^= 1; m_issued = 0;
          if (m_mode == 0) begin
            m_mode = 1; m_pass++; m_issuing = 1;
          end else begin
            m_level++;
            if (m_level == DL) m_done = 1;
            else begin m_pass++; m_mode = 0; m_issuing = 1; end
          end
        end
      end
    end
  end

  // per-cycle compare on the falling edge, then drive ready / results
  initial begin : cmp
    int exp_v;
    bit iss;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_v = ((m_issuing != 0) && (m_cnt < MAXO)) ? 1 : 0;
        chk("rd_valid", int'(bus.rd_valid), exp_v);
        if (exp_v != 0) begin
          chk("rd_mode",  int'(bus.rd_mode),  m_mode);
          chk("rd_line",  int'(bus.rd_line),  m_issued / per_line(m_pass));
          chk("rd_pixel", int'(bus.rd_pixel), 2 * (m_issued % per_line(m_pass)));
        end
        chk("bank_sel", int'(bus.bank_sel), m_bank);
        chk("level",    int'(level), m_level);
        chk("busy",     int'(busy),  m_active);
        chk("done",     int'(done),  m_done);
        chk("err",      int'(err),   m_err);
        if (done) begin
          done_cnt++;
          done_level = int'(level);
          done_bank  = int'(bus.bank_sel);
        end
      end
      bus.rd_ready = ($urandom_range(0, 99) < ready_pct);
      iss = bus.rd_valid && bus.rd_ready;
      sched = sched >> 1;
      if (iss) begin
        sched[delay] = 1'b1;
        issue_cnt++;
      end
      if (!rst) sched = '0;
      bus.res_valid = sched[0] | extra_res;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_full(input string nm);
    int d0, n;
    issue_cnt = 0;
    d0 = done_cnt;
    pulse_start();
    @(posedge clk); #1;
    chk({nm, "_busy_on"}, int'(busy), 1);
    chk({nm, "_err_clr"}, int'(err), 0);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin @(posedge clk); n++; end
    chk({nm, "_done_once"}, done_cnt - d0, 1);
    chk({nm, "_issues"}, issue_cnt, TOTAL_ISSUES);
    chk({nm, "_done_level"}, done_level, DL);
    chk({nm, "_done_bank"}, done_bank, 0);
    repeat (3) @(posedge clk); #1;
    chk({nm, "_busy_off"}, int'(busy), 0);
    chk({nm, "_no_extra_done"}, done_cnt - d0, 1);
  endtask

  initial begin : main
    int n, d0;
    bus.rd_ready = 1'b0;
    bus.res_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_busy",     int'(busy), 0);
    chk("rst_done",     int'(done), 0);
    chk("rst_err",      int'(err), 0);
    chk("rst_level",    int'(level), 0);
    chk("rst_bank",     int'(bus.bank_sel), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // full-rate, result 2 cycles after issue: issue and result overlap
    ready_pct = 100; delay = 2;
    run_full("full_rate");

    // random stalls with a window-limited long-latency MAC
    ready_pct = 50; delay = 6;
    run_full("random");

    // abort mid row pass with results in flight
    ready_pct = 100; delay = 3;
    issue_cnt = 0;
    pulse_start();
    n = 0;
    while (issue_cnt < 10 && n < 200) begin @(posedge clk); n++; end
    chk("abort_reach", int'(issue_cnt >= 10), 1);
    d0 = done_cnt;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    chk("abort_busy",     int'(busy), 0);
    chk("abort_rd_valid", int'(bus.rd_valid), 0);
    chk("abort_done",     int'(done), 0);
    repeat (12) @(posedge clk); #1;
    chk("abort_late_err", int'(err), 0);
    chk("abort_no_done",  done_cnt - d0, 0);
    run_full("after_abort");

    // spurious result while idle
    @(posedge clk); #1 extra_res = 1'b1;
    @(posedge clk); #1 extra_res = 1'b0;
    @(posedge clk); #1;
    chk("spurious_err", int'(err), 1);
    run_full("err_cleared");

    // asynchronous reset during a column pass
    ready_pct = 100; delay = 2;
    pulse_start();
    n = 0;
    while (!(bus.rd_mode && bus.rd_valid) && n < 500) begin @(posedge clk); #1; n++; end
    chk("col_reached", int'(bus.rd_mode && bus.rd_valid), 1);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_rd_valid", int'(bus.rd_valid), 0);
    chk("arst_rd_mode",  int'(bus.rd_mode), 0);
    chk("arst_rd_line",  int'(bus.rd_line), 0);
    chk("arst_rd_pixel", int'(bus.rd_pixel), 0);
    chk("arst_bank",     int'(bus.bank_sel), 0);
    chk("arst_level",    int'(level), 0);
    chk("arst_busy",     int'(busy), 0);
    chk("arst_done",     int'(done), 0);
    chk("arst_err",      int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
